// File: rtl/exe_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// One operation at a time: IDLE -> PREP -> RUN (WIDTH cycles) -> FIX -> DONE.
module exe_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
  state_t state, state_nx;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, dvs, lo;
  logic [WIDTH:0]   hi;
  logic             neg;
  logic [CW-1:0]    cnt;

  logic             div_op, sa_s, sb_s, sa, sb, div_zero, div_ovf, neg_nx;
  logic [WIDTH-1:0] ma, mb, dres, dres_s, fix_val;
  logic [WIDTH:0]   msum, dshift, ddiff;
  logic [2*WIDTH-1:0] prod;

  // Operand signedness: MULH/DIV/REM treat both as signed, MULHSU only rs1.
  assign div_op   = op_q[2];
  assign sa_s     = (op_q == 3'd1) | (op_q == 3'd2) | (op_q[2] & ~op_q[0]);
  assign sb_s     = (op_q == 3'd1) | (op_q[2] & ~op_q[0]);
  assign sa       = sa_s & a_q[WIDTH-1];
  assign sb       = sb_s & b_q[WIDTH-1];
  assign ma       = sa ? -a_q : a_q;
  assign mb       = sb ? -b_q : b_q;
  assign div_zero = div_op & (b_q == '0);
  assign div_ovf  = div_op & ~op_q[0] & (a_q == MIN) & (&b_q);
  assign neg_nx   = (op_q[2] & op_q[1]) | (op_q == 3'd2) ? sa : (sa ^ sb);

  // hi:lo is the product for multiply, remainder:quotient for divide.
  assign msum   = {1'b0, hi[WIDTH-1:0]} + (lo[0] ? {1'b0, dvs} : '0);
  assign dshift = {hi[WIDTH-1:0], lo[WIDTH-1]};
  assign ddiff  = dshift - {1'b0, dvs};

  assign prod    = neg ? -{hi[WIDTH-1:0], lo} : {hi[WIDTH-1:0], lo};
  assign dres    = op_q[1] ? hi[WIDTH-1:0] : lo;
  assign dres_s  = neg ? -dres : dres;
  assign fix_val = div_op ? dres_s : ((op_q == 3'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !kill) state_nx = PREP;
      PREP:    state_nx = (div_zero || div_ovf) ? DONE : RUN;
      RUN:     if (cnt == CW'(1)) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (kill && state != IDLE) state_nx = IDLE;
  end

  // A kill freezes the datapath so a flushed op never touches result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      dvs    <= '0;
      lo     <= '0;
      hi     <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (!kill) begin
      case (state)
        IDLE: if (start) begin
          op_q <= op;
          a_q  <= a;
          b_q  <= b;
        end
        PREP: begin
          neg <= neg_nx;
          cnt <= CW'(WIDTH);
          hi  <= '0;
          if (div_zero)     result <= op_q[1] ? a_q : '1;
          else if (div_ovf) result <= op_q[1] ? '0 : MIN;
          else if (div_op) begin
            lo  <= ma;
            dvs <= mb;
          end else begin
            lo  <= mb;
            dvs <= ma;
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (div_op) begin
            if (!ddiff[WIDTH]) begin
              hi <= ddiff;
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= dshift;
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi <= {1'b0, msum[WIDTH:1]};
            lo <= {msum[0], lo[WIDTH-1:1]};
          end
        end
        FIX:     result <= fix_val;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_exe_muldiv_seq.sv
// Randomized and directed bench for exe_muldiv_seq against an arithmetic reference model.
module tb_exe_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        kill = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int nchk = 0;
  int nerr = 0;

  exe_muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .kill(kill), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic [63:0] p;
    logic ovf;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * $signed({32'b0, y}); return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(x) / $signed(y));
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 0)) return 2;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, scramble inputs after accept, wait (bounded) for done.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output int lat, output int bc, output logic got);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 1; bc = 0;
    while (1) begin
      if (busy) bc++;
      if (done || lat >= 100) break;
      @(negedge clk);
      lat++;
    end
    got = done;
    r   = result;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    nchk++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done); end
    nchk++; if (result !== 32'h0) begin nerr++; $display("FAIL reset_result got %h want 0", result); end
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]  ot[12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] xt[12] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                            32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] yt[12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2,
                            32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] et[12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                            32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    int          lt[12] = '{35, 35, 35, 35, 35, 35, 35, 35, 2, 2, 2, 2};
    logic [31:0] r;
    int lat, bc;
    logic got;
    for (int i = 0; i < 12; i++) begin
      do_op(ot[i], xt[i], yt[i], r, lat, bc, got);
      nchk++; if (!got) begin nerr++; $display("FAIL dir%0d_timeout no done within 100 cycles", i); end
      nchk++; if (r !== et[i]) begin nerr++; $display("FAIL dir%0d_result got %h want %h", i, r, et[i]); end
      nchk++; if (lat != lt[i]) begin nerr++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, lt[i]); end
      nchk++; if (bc != lt[i]) begin nerr++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, lt[i]); end
    end
    @(negedge clk);
    nchk++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL idle_after_done busy %b done %b want 0 0", busy, done); end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y, r, e;
    int lat, bc, el;
    logic got;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7)); x = pick(); y = pick();
      e = model(o, x, y); el = model_lat(o, x, y);
      do_op(o, x, y, r, lat, bc, got);
      nchk++; if (!got || r !== e) begin nerr++; $display("FAIL rnd%0d_result op %0d a %h b %h got %h want %h", i, o, x, y, r, e); end
      nchk++; if (lat != el) begin nerr++; $display("FAIL rnd%0d_latency op %0d got %0d want %0d", i, o, lat, el); end
    end
  endtask

  task automatic test_kill();
    logic [31:0] r;
    int lat, bc, seen;
    logic got;
    do_op(3'd0, 32'd5, 32'd6, r, lat, bc, got);
    nchk++; if (r !== 32'd30) begin nerr++; $display("FAIL kill_pre_result got %h want 1e", r); end
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL kill_busy got %b want 0", busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    nchk++; if (seen != 0) begin nerr++; $display("FAIL kill_no_done got %0d pulses want 0", seen); end
    nchk++; if (result !== 32'd30) begin nerr++; $display("FAIL kill_result_held got %h want 1e", result); end
    do_op(3'd0, 32'd3, 32'd4, r, lat, bc, got);
    nchk++; if (r !== 32'd12 || lat != 35) begin nerr++; $display("FAIL kill_then_mul got %h lat %0d want c lat 35", r, lat); end
  endtask

  task automatic test_start_held();
    int dc, d1, d2;
    logic [31:0] e;
    e = model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    dc = 0; d1 = 0; d2 = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    for (int n = 1; n <= 72; n++) begin
      @(negedge clk);
      if (done) begin
        dc++;
        if (dc == 1) d1 = n; else d2 = n;
        nchk++; if (result !== e) begin nerr++; $display("FAIL held_result%0d got %h want %h", dc, result, e); end
      end
      if (n == 71) start = 1'b0;
    end
    nchk++; if (dc != 2 || d1 != 35 || d2 != 71) begin nerr++; $display("FAIL held_accepts got %0d dones at %0d,%0d want 2 at 35,71", dc, d1, d2); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL held_idle got busy %b want 0", busy); end
    start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL start_kill_idle got busy %b want 0", busy); end
  endtask

  task automatic test_rst_mid();
    int seen;
    logic [31:0] r;
    int lat, bc;
    logic got;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    nchk++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL rst_mid_ctrl busy %b done %b want 0 0", busy, done); end
    nchk++; if (result !== 32'h0) begin nerr++; $display("FAIL rst_mid_result got %h want 0", result); end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    nchk++; if (seen != 0) begin nerr++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", seen); end
    do_op(3'd7, 32'hFFFF_FFF9, 32'd10, r, lat, bc, got);
    nchk++; if (r !== model(3'd7, 32'hFFFF_FFF9, 32'd10)) begin nerr++; $display("FAIL rst_mid_recover got %h want %h", r, model(3'd7, 32'hFFFF_FFF9, 32'd10)); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_kill();
    test_start_held();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/exe_muldiv_seq.md
Name: exe_muldiv_seq

Overview:
- Sequencer for the execute stage's iterative RV32M unit, holding its own FSM plus shift/add-subtract engine.
- The exe stage pulses start when a MUL/DIV-class instruction is in EX and holds the pipeline (exe_rdy low) until done.
- Runs one operation at a time; a pipeline flush aborts it via kill.

Parameters:
WIDTH, 32, operand/result width (counter sized $clog2(WIDTH)+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a  in  WIDTH  rs1 operand (forwarded value), captured on accept
b  in  WIDTH  rs2 operand, captured on accept
kill  in  1  abort current op (branch flush)
busy  out  1  high from accept through DONE cycle
done  out  1  one-cycle pulse, result valid
result  out  WIDTH  result; held until next accept

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE: start=1 captures op/a/b, goes to PREP; busy=1 from the next cycle.
- PREP (1 cycle):
  - Take magnitudes per signedness. Signed: MULH/DIV/REM both operands; MULHSU a only. Record result sign.
  - Div by zero (b=0): go to DONE. Result: DIV/DIVU 0xFFFFFFFF, REM/REMU = a.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): go to DONE. Result: DIV 0x80000000, REM 0.
  - Otherwise load counter=WIDTH and go to RUN.
- RUN: one iteration per cycle, WIDTH cycles, counter decrements, leave at counter==1.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring divide, one quotient bit per cycle; remainder WIDTH+1 bits internally.
- FIX (1 cycle): negate if sign flag set. Quotient sign = sa^sb; remainder sign = sa; product sign = sa^sb for MULH, sa for MULHSU. Select low half (MUL) or high half (MULH*). Register result. Go to DONE.
- DONE (1 cycle): done=1, busy=1, then IDLE. start in the DONE cycle is ignored; the next accept is possible the cycle after.
- Latency from the accept edge to the done cycle:
  - normal ops: WIDTH+3 cycles (35 for WIDTH=32)
  - special cases: 2 cycles
- start while not IDLE: ignored. Operands are not re-sampled.
- kill: any non-IDLE state goes to IDLE next edge; done stays 0, result is not updated. kill in IDLE has no effect. kill and start in the same IDLE cycle: kill wins, no accept.
- Reset mid-operation: immediate return to IDLE; no done pulse after release.
- MUL ignores signedness (low half identical); still takes the full latency.
- All arithmetic is modulo 2^WIDTH on outputs; no X propagation from unused registers.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> done exactly 35 cycles after accept, result 0xFFFFFFEB; busy high for 35 cycles; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9(-7) / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; each 35 cycles.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, done 2 cycles after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, 2 cycles.
- Start DIVU, assert kill at RUN cycle 10 -> busy 0 next cycle, no done, result unchanged; immediate new MUL 3*4 accepted -> 12.
- start held high through an op, and start+kill together in IDLE -> only one accept per IDLE visit, no accept with kill; rst pulsed low mid-RUN -> busy/done/result 0 asynchronously, no done after release.
